// File: rtl/booth_divider.sv
`default_nettype none
// ============================================================================
// booth_divider : sequential signed 2N/N restoring divider, one bit per clock
// Revision 1.0
// ============================================================================
module booth_divider #(
  parameter int N = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(2*N);
  localparam logic [2*N-1:0] C_MIN = {1'b1, {(2*N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [2*N-1:0]  r_dvd;    // dividend magnitude, quotient bits shift in at the LSB
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_dmag;
  logic [CW-1:0]   r_count;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_zero;
  logic            r_ovf;

  logic [2*N-1:0]  w_dvd_mag;
  logic [N-1:0]    w_dvs_mag;
  logic [N:0]      w_shift;
  logic [N+1:0]    w_diff;
  logic [2*N-1:0]  w_q_fix;
  logic [N-1:0]    w_r_fix;

  assign w_dvd_mag = dividend[2*N-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[N-1]    ? -divisor  : divisor;

  // The partial remainder stays below |divisor| <= 2^(N-1), so one extra bit
  // covers the shifted value and a second one carries the borrow.
  assign w_shift = {r_rem, r_dvd[2*N-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dmag};

  assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_dmag      <= '0;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_dvd   <= w_dvd_mag;
            r_rem   <= '0;
            r_dmag  <= w_dvs_mag;
            r_count <= CW'(2*N-1);
            r_neg_q <= dividend[2*N-1] ^ divisor[N-1];
            r_neg_r <= dividend[2*N-1];
            r_zero  <= (divisor == '0);
            r_ovf   <= (dividend == C_MIN) && (divisor == '1);
            busy    <= 1'b1;
            r_state <= S_DIVIDE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_DIVIDE: begin
          if (!w_diff[N+1]) begin
            r_rem <= w_diff[N-1:0];
          end else begin
            r_rem <= w_shift[N-1:0];
          end
          r_dvd <= {r_dvd[2*N-2:0], ~w_diff[N+1]};
          if (r_count == '0) begin
            r_state <= S_FIXUP;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end

        S_FIXUP: begin
          if (r_zero) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (r_ovf) begin
            quotient    <= C_MIN;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= w_q_fix;
            remainder   <= w_r_fix;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_DONE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
